axi_slv_wr_responder: RTL and testbench

Slave-side AXI write-channel endpoint for the crossbar test environment. It sits directly downstream of the master write driver, on the slave side of the crossbar. It queues accepted AW requests, consumes W beats against the queued burst length and ID, and returns one B response per burst with a protocol-check result. Per-beat error pulses and a running data signature feed the scoreboard.

---
 rtl/axi_slv_wr_responder_if.sv | 35 +++
 rtl/axi_slv_wr_responder.sv | 203 ++++++++++++++++++++
 tb/tb_axi_slv_wr_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_slv_wr_responder_if.sv
// AXI write-channel bundle (AW, W, B) between the master write driver
// and the slave-side write responder.
interface axi_slv_wr_responder_if #(
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [AXI_ID_W-1:0]     awid;
  logic [7:0]              awlen;
  logic                    wvalid;
  logic                    wready;
  logic [AXI_ID_W-1:0]     wid;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid;
  logic                    bready;
  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;

  modport master (
    output awvalid, awid, awlen,
    output wvalid, wid, wdata, wstrb, wlast,
    output bready,
    input  awready, wready, bvalid, bid, bresp
  );

  modport slave (
    input  awvalid, awid, awlen,
    input  wvalid, wid, wdata, wstrb, wlast,
    input  bready,
    output awready, wready, bvalid, bid, bresp
  );
endinterface

// File: rtl/axi_slv_wr_responder.sv
// Slave-side AXI write responder: queues AW requests, consumes W beats
// against the head burst, and returns one B per burst (SLVERR when any
// beat of the burst broke protocol). Per-beat error pulses and a running
// XOR signature of strobed write data are exported for the scoreboard.
// Optional feature macro: AXI_WSTRB_CHK_EN (flags beats with all-zero
// strobes as errors).
module axi_slv_wr_responder #(
  parameter int AXI_ID_W     = 4,
  parameter int AXI_DATA_W   = 32,
  parameter int SLV_OSTD_NUM = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  axi_slv_wr_responder_if.slave bus,
  output logic                  err_wid,
  output logic                  err_wlast,
  output logic                  err_wstrb,
  output logic [AXI_DATA_W-1:0] wdata_sig
);
  localparam int PTR_W  = $clog2(SLV_OSTD_NUM);
  localparam int CNT_W  = PTR_W + 1;
  localparam int STRB_W = AXI_DATA_W / 8;

  // AW queue storage and state
  logic [AXI_ID_W-1:0] aw_id_q   [SLV_OSTD_NUM];
  logic [AXI_ID_W-1:0] aw_id_d   [SLV_OSTD_NUM];
  logic [7:0]          aw_len_q  [SLV_OSTD_NUM];
  logic [7:0]          aw_len_d  [SLV_OSTD_NUM];
  logic [PTR_W-1:0]    aw_wr_ptr_q, aw_wr_ptr_d;
  logic [PTR_W-1:0]    aw_rd_ptr_q, aw_rd_ptr_d;
  logic [CNT_W-1:0]    aw_cnt_q, aw_cnt_d;

  // B queue storage and state
  logic [AXI_ID_W-1:0] b_id_q    [SLV_OSTD_NUM];
  logic [AXI_ID_W-1:0] b_id_d    [SLV_OSTD_NUM];
  logic [1:0]          b_resp_q  [SLV_OSTD_NUM];
  logic [1:0]          b_resp_d  [SLV_OSTD_NUM];
  logic [PTR_W-1:0]    b_wr_ptr_q, b_wr_ptr_d;
  logic [PTR_W-1:0]    b_rd_ptr_q, b_rd_ptr_d;
  logic [CNT_W-1:0]    b_cnt_q, b_cnt_d;

  // Burst tracking, error pulses, signature
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  sticky_q, sticky_d;
  logic                  err_wid_q, err_wid_d;
  logic                  err_wlast_q, err_wlast_d;
  logic                  err_wstrb_q, err_wstrb_d;
  logic [AXI_DATA_W-1:0] wdata_sig_q, wdata_sig_d;

  logic                  aw_full, aw_empty, b_full, b_empty;
  logic                  aw_push, w_acc, b_pop, burst_end, exp_last;
  logic                  id_err, last_err, strb_err;
  logic [AXI_ID_W-1:0]   head_id;
  logic [7:0]            head_len;
  logic [AXI_DATA_W-1:0] byte_mask;

  assign aw_full  = (aw_cnt_q == CNT_W'(SLV_OSTD_NUM));
  assign aw_empty = (aw_cnt_q == '0);
  assign b_full   = (b_cnt_q == CNT_W'(SLV_OSTD_NUM));
  assign b_empty  = (b_cnt_q == '0);

  // Handshake outputs depend only on registered queue occupancy.
  assign bus.awready = !aw_full;
  assign bus.wready  = !aw_empty && !b_full;
  assign bus.bvalid  = !b_empty;
  assign bus.bid     = b_id_q[b_rd_ptr_q];
  assign bus.bresp   = b_resp_q[b_rd_ptr_q];

  assign err_wid   = err_wid_q;
  assign err_wlast = err_wlast_q;
  assign err_wstrb = err_wstrb_q;
  assign wdata_sig = wdata_sig_q;

  assign head_id  = aw_id_q[aw_rd_ptr_q];
  assign head_len = aw_len_q[aw_rd_ptr_q];

  // Beat checks against the head burst and next-state for all queues.
  always_comb begin
    aw_push   = bus.awvalid && !aw_full;
    w_acc     = bus.wvalid && !aw_empty && !b_full;
    b_pop     = !b_empty && bus.bready;
    exp_last  = (beat_cnt_q == head_len);
    id_err    = w_acc && (bus.wid != head_id);
    last_err  = w_acc && (bus.wlast != exp_last);
`ifdef AXI_WSTRB_CHK_EN
    strb_err  = w_acc && (bus.wstrb == '0);
`else
    strb_err  = 1'b0;
`endif
    // Either an early wlast or the expected last beat closes the burst.
    burst_end = w_acc && (bus.wlast || exp_last);

    byte_mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      byte_mask[i*8 +: 8] = {8{bus.wstrb[i]}};
    end

    aw_id_d     = aw_id_q;
    aw_len_d    = aw_len_q;
    aw_wr_ptr_d = aw_wr_ptr_q;
    aw_rd_ptr_d = aw_rd_ptr_q;
    aw_cnt_d    = aw_cnt_q;
    b_id_d      = b_id_q;
    b_resp_d    = b_resp_q;
    b_wr_ptr_d  = b_wr_ptr_q;
    b_rd_ptr_d  = b_rd_ptr_q;
    b_cnt_d     = b_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    sticky_d    = sticky_q;
    wdata_sig_d = wdata_sig_q;
    err_wid_d   = id_err;
    err_wlast_d = last_err;
    err_wstrb_d = strb_err;

    if (aw_push) begin
      aw_id_d[aw_wr_ptr_q]  = bus.awid;
      aw_len_d[aw_wr_ptr_q] = bus.awlen;
      aw_wr_ptr_d           = aw_wr_ptr_q + 1'b1;
    end

    if (w_acc) begin
      wdata_sig_d = wdata_sig_q ^ (bus.wdata & byte_mask);
      if (burst_end) begin
        // Errors on the closing beat itself still count toward bresp.
        b_id_d[b_wr_ptr_q]   = head_id;
        b_resp_d[b_wr_ptr_q] = (sticky_q || id_err || last_err || strb_err) ? 2'b10 : 2'b00;
        b_wr_ptr_d           = b_wr_ptr_q + 1'b1;
        aw_rd_ptr_d          = aw_rd_ptr_q + 1'b1;
        beat_cnt_d           = '0;
        sticky_d             = 1'b0;
      end else begin
        beat_cnt_d = beat_cnt_q + 8'd1;
        sticky_d   = sticky_q || id_err || last_err || strb_err;
      end
    end

    if (b_pop) begin
      b_rd_ptr_d = b_rd_ptr_q + 1'b1;
    end

    aw_cnt_d = aw_cnt_q + CNT_W'(aw_push) - CNT_W'(burst_end);
    b_cnt_d  = b_cnt_q + CNT_W'(burst_end) - CNT_W'(b_pop);

    if (srst) begin
      aw_id_d     = '{default: '0};
      aw_len_d    = '{default: '0};
      aw_wr_ptr_d = '0;
      aw_rd_ptr_d = '0;
      aw_cnt_d    = '0;
      b_id_d      = '{default: '0};
      b_resp_d    = '{default: '0};
      b_wr_ptr_d  = '0;
      b_rd_ptr_d  = '0;
      b_cnt_d     = '0;
      beat_cnt_d  = '0;
      sticky_d    = 1'b0;
      wdata_sig_d = '0;
      err_wid_d   = 1'b0;
      err_wlast_d = 1'b0;
      err_wstrb_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_id_q     <= '{default: '0};
      aw_len_q    <= '{default: '0};
      aw_wr_ptr_q <= '0;
      aw_rd_ptr_q <= '0;
      aw_cnt_q    <= '0;
      b_id_q      <= '{default: '0};
      b_resp_q    <= '{default: '0};
      b_wr_ptr_q  <= '0;
      b_rd_ptr_q  <= '0;
      b_cnt_q     <= '0;
      beat_cnt_q  <= '0;
      sticky_q    <= 1'b0;
      wdata_sig_q <= '0;
      err_wid_q   <= 1'b0;
      err_wlast_q <= 1'b0;
      err_wstrb_q <= 1'b0;
    end else begin
      aw_id_q     <= aw_id_d;
      aw_len_q    <= aw_len_d;
      aw_wr_ptr_q <= aw_wr_ptr_d;
      aw_rd_ptr_q <= aw_rd_ptr_d;
      aw_cnt_q    <= aw_cnt_d;
      b_id_q      <= b_id_d;
      b_resp_q    <= b_resp_d;
      b_wr_ptr_q  <= b_wr_ptr_d;
      b_rd_ptr_q  <= b_rd_ptr_d;
      b_cnt_q     <= b_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      sticky_q    <= sticky_d;
      wdata_sig_q <= wdata_sig_d;
      err_wid_q   <= err_wid_d;
      err_wlast_q <= err_wlast_d;
      err_wstrb_q <= err_wstrb_d;
    end
  end
endmodule

// File: tb/tb_axi_slv_wr_responder.sv
// Directed bench for axi_slv_wr_responder with a B-response scoreboard.
module tb_axi_slv_wr_responder;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        srst = 1'b0;
  logic        err_wid, err_wlast, err_wstrb;
  logic [31:0] wdata_sig;

  int checks = 0;
  int errors = 0;
  int n_wid = 0, n_wlast = 0, n_wstrb = 0;
  int exp_wid = 0, exp_wlast = 0, exp_wstrb = 0;
  logic [31:0] sig_model = '0;
  logic [5:0]  sb[$];

  always #5 aclk = ~aclk;

  axi_slv_wr_responder_if #(.AXI_ID_W(4), .AXI_DATA_W(32)) bus ();

  axi_slv_wr_responder #(
    .AXI_ID_W(4), .AXI_DATA_W(32), .SLV_OSTD_NUM(4)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .bus       (bus.slave),
    .err_wid   (err_wid),
    .err_wlast (err_wlast),
    .err_wstrb (err_wstrb),
    .wdata_sig (wdata_sig)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Error-pulse counters and B scoreboard, sampled mid-cycle.
  always @(negedge aclk) begin
    logic [5:0] e;
    if (err_wid === 1'b1)   n_wid++;
    if (err_wlast === 1'b1) n_wlast++;
    if (err_wstrb === 1'b1) n_wstrb++;
    if (bus.bvalid === 1'b1 && bus.bready === 1'b1) begin
      check("b_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("b_id_resp", {58'd0, bus.bid, bus.bresp}, {58'd0, e});
      end
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [7:0] len);
    logic ok = 1'b0;
    bus.awvalid = 1'b1; bus.awid = id; bus.awlen = len;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (bus.awready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    check("aw_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_w(input logic [3:0] id, input logic [31:0] data,
                        input logic [3:0] strb, input logic last);
    logic ok = 1'b0;
    logic [31:0] m;
    bus.wvalid = 1'b1; bus.wid = id; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (bus.wready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge aclk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("w_accept", 64'(ok), 64'd1);
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    if (ok) sig_model = sig_model ^ (data & m);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (sb.size() == 0) break;
    end
    repeat (2) @(negedge aclk);
    check("sb_drain", 64'(sb.size()), 64'd0);
    check("err_wid_cnt", 64'(n_wid), 64'(exp_wid));
    check("err_wlast_cnt", 64'(n_wlast), 64'(exp_wlast));
    check("err_wstrb_cnt", 64'(n_wstrb), 64'(exp_wstrb));
    check("wdata_sig", 64'(wdata_sig), 64'(sig_model));
    @(posedge aclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awvalid = 1'b0; bus.awid = '0; bus.awlen = '0;
    bus.wvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    check("rst_awready", 64'(bus.awready), 64'd1);
    check("rst_wready", 64'(bus.wready), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_bid_bresp", {58'd0, bus.bid, bus.bresp}, 64'd0);
    check("rst_err", {61'd0, err_wid, err_wlast, err_wstrb}, 64'd0);
    check("rst_sig", 64'(wdata_sig), 64'd0);
    @(posedge aclk); #1;

    // Clean 4-beat burst
    send_aw(4'h5, 8'd3);
    sb.push_back({4'h5, 2'b00});
    send_w(4'h5, 32'h0000_1111, 4'hF, 1'b0);
    send_w(4'h5, 32'h0000_2222, 4'hF, 1'b0);
    send_w(4'h5, 32'h0000_4444, 4'hF, 1'b0);
    send_w(4'h5, 32'hA5A5_0000, 4'hF, 1'b1);
    drain();

    // Early wlast, then a fresh burst must start from beat 0
    send_aw(4'h2, 8'd3);
    sb.push_back({4'h2, 2'b10});
    send_w(4'h2, 32'h0101_0101, 4'hF, 1'b0);
    send_w(4'h2, 32'h0202_0202, 4'hF, 1'b1);
    exp_wlast++;
    send_aw(4'h6, 8'd1);
    sb.push_back({4'h6, 2'b00});
    send_w(4'h6, 32'h0303_0303, 4'hF, 1'b0);
    send_w(4'h6, 32'h0404_0404, 4'hF, 1'b1);
    drain();

    // Single beat with wrong ID
    send_aw(4'h1, 8'd0);
    sb.push_back({4'h1, 2'b10});
    send_w(4'h3, 32'hCAFE_F00D, 4'hF, 1'b1);
    exp_wid++;
    drain();

    // Fill both queues with bready held low
    bus.bready = 1'b0;
    for (int i = 0; i < 4; i++) send_aw(4'(8 + i), 8'd0);
    bus.awvalid = 1'b1; bus.awid = 4'hC; bus.awlen = 8'd0;
    repeat (3) @(negedge aclk);
    check("aw_full_awready", 64'(bus.awready), 64'd0);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({4'(8 + i), 2'b00});
      send_w(4'(8 + i), 32'(32'h1000 * (i + 1)), 4'hF, 1'b1);
    end
    repeat (2) @(negedge aclk);
    check("b_full_wready", 64'(bus.wready), 64'd0);
    check("b_full_bvalid", 64'(bus.bvalid), 64'd1);
    check("b_hold_bid", {58'd0, bus.bid, bus.bresp}, {58'd0, 4'h8, 2'b00});
    @(posedge aclk); #1;
    bus.bready = 1'b1;
    drain();

    // Strobe masking into the signature from a cleared state
    srst = 1'b1;
    @(posedge aclk); #1;
    srst = 1'b0;
    sig_model = '0;
    check("srst_sig", 64'(wdata_sig), 64'd0);
    send_aw(4'h3, 8'd1);
    sb.push_back({4'h3, 2'b00});
    send_w(4'h3, 32'hFFFF_FFFF, 4'b0001, 1'b0);
    send_w(4'h3, 32'h1234_5678, 4'hF, 1'b1);
    check("sig_strobed", 64'(wdata_sig), 64'h1234_5687);
    drain();

    // All-zero strobe beat
    send_aw(4'h4, 8'd0);
`ifdef AXI_WSTRB_CHK_EN
    sb.push_back({4'h4, 2'b10});
    exp_wstrb++;
`else
    sb.push_back({4'h4, 2'b00});
`endif
    send_w(4'h4, 32'hDEAD_BEEF, 4'h0, 1'b1);
    drain();

    // Async reset in the middle of a long burst
    send_aw(4'h7, 8'd7);
    send_w(4'h7, 32'h0000_00AA, 4'hF, 1'b0);
    send_w(4'h7, 32'h0000_00BB, 4'hF, 1'b0);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    sig_model = '0;
    repeat (3) @(negedge aclk);
    check("mid_rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("mid_rst_awready", 64'(bus.awready), 64'd1);
    check("mid_rst_wready", 64'(bus.wready), 64'd0);
    check("mid_rst_sig", 64'(wdata_sig), 64'd0);
    @(posedge aclk); #1;
    send_aw(4'h7, 8'd1);
    sb.push_back({4'h7, 2'b00});
    send_w(4'h7, 32'h5555_0000, 4'hF, 1'b0);
    send_w(4'h7, 32'h0000_5555, 4'hF, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
